alu_operand_entry: RTL and testbench

- Sequential front end that replaces direct switch-to-ALU wiring on the DE-series board.
- Debounces the push-buttons and lets the user enter operand A, operand B and the opcode one after another from the switches.
- Drives the 16-bit ALU with the held values, captures its result and flags, and presents them for the hex/LED display path.
- Data flow is board inputs into ALU, the opposite direction to the display decoders.

---
 rtl/alu_operand_entry_pkg.sv | 35 +++
 rtl/alu_operand_entry_key_debounce.sv | 49 ++++
 rtl/alu_operand_entry.sv | 119 +++++++++++
 tb/tb_alu_operand_entry.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_operand_entry_pkg.sv
// Shared constants for the ALU operand-entry front end: ALU opcodes, FSM state
// encoding and the switch-to-opcode mapping.
package alu_entry_pkg;

  localparam logic [4:0] ALU_ADD = 5'd0;
  localparam logic [4:0] ALU_SUB = 5'd8;
  localparam logic [4:0] ALU_CMP = 5'd10;
  localparam logic [4:0] ALU_AND = 5'd14;
  localparam logic [4:0] ALU_OR  = 5'd16;
  localparam logic [4:0] ALU_XOR = 5'd18;
  localparam logic [4:0] ALU_NOT = 5'd20;
  localparam logic [4:0] ALU_LSH = 5'd21;

  localparam logic [2:0] S_A    = 3'd0;
  localparam logic [2:0] S_B    = 3'd1;
  localparam logic [2:0] S_OP   = 3'd2;
  localparam logic [2:0] S_EXEC = 3'd3;
  localparam logic [2:0] S_SHOW = 3'd4;

  function automatic logic [4:0] map_opcode(input logic [2:0] sel);
    logic [4:0] op;
    case (sel)
      3'b000:  op = ALU_ADD;
      3'b001:  op = ALU_SUB;
      3'b010:  op = ALU_AND;
      3'b011:  op = ALU_OR;
      3'b100:  op = ALU_XOR;
      3'b101:  op = ALU_NOT;
      3'b110:  op = ALU_LSH;
      default: op = ALU_CMP;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_operand_entry_key_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability counter and a
// one-cycle press pulse on an accepted 1->0 transition (active-low key).
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_reg;
  logic             sync2_reg;
  logic             stable_reg;
  logic             stable_dly_reg;
  logic             press_reg;
  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg      <= 1'b1;
      sync2_reg      <= 1'b1;
      stable_reg     <= 1'b1;
      stable_dly_reg <= 1'b1;
      press_reg      <= 1'b0;
      cnt_reg        <= '0;
    end else begin
      sync1_reg      <= key_n;
      sync2_reg      <= sync1_reg;
      stable_dly_reg <= stable_reg;
      press_reg      <= stable_dly_reg & ~stable_reg;
      // Count consecutive differing samples; any agreeing sample restarts the run.
      if (sync2_reg == stable_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_LAST) begin
        stable_reg <= sync2_reg;
        cnt_reg    <= '0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign press = press_reg;

endmodule

// File: rtl/alu_operand_entry.sv
// Sequential operand/opcode entry for the 16-bit ALU with result capture.
// Optional chaining of results into operand A: define ALU_ENTRY_ACCUMULATE_EN.
module alu_operand_entry
  import alu_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic [1:0]  KEY,
  input  logic [9:0]  SW,
  input  logic [15:0] alu_y,
  input  logic [4:0]  alu_flags,
  output logic [15:0] a,
  output logic [15:0] b,
  output logic [4:0]  alu_op,
  output logic [15:0] disp,
  output logic [4:0]  flags_led,
  output logic [2:0]  state_o,
  output logic        result_valid
);

  logic [1:0]  press;
  logic [2:0]  state_reg;
  logic [15:0] a_reg;
  logic [15:0] b_reg;
  logic [4:0]  op_reg;
  logic [15:0] y_reg;
  logic [4:0]  flags_reg;
  logic        valid_reg;
  logic [15:0] operand;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_key
      key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
      ) u_key_debounce (
        .clk  (CLOCK_50),
        .rst  (reset),
        .key_n(KEY[gi]),
        .press(press[gi])
      );
    end
  endgenerate

  assign operand = {{9{SW[6]}}, SW[6:0]};

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_reg <= S_A;
      a_reg     <= '0;
      b_reg     <= '0;
      op_reg    <= '0;
      y_reg     <= '0;
      flags_reg <= '0;
      valid_reg <= 1'b0;
    end else if (press[1]) begin
      state_reg <= S_A;
      a_reg     <= '0;
      b_reg     <= '0;
      op_reg    <= '0;
      y_reg     <= '0;
      flags_reg <= '0;
      valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_A: if (press[0]) begin
          a_reg     <= operand;
          state_reg <= S_B;
        end
        S_B: if (press[0]) begin
          b_reg     <= operand;
          state_reg <= S_OP;
        end
        S_OP: if (press[0]) begin
          op_reg    <= map_opcode(SW[9:7]);
          state_reg <= S_EXEC;
        end
        // Single-cycle capture; an advance arriving here is deliberately dropped.
        S_EXEC: begin
          y_reg     <= alu_y;
          flags_reg <= alu_flags;
          valid_reg <= 1'b1;
          state_reg <= S_SHOW;
        end
        S_SHOW: if (press[0]) begin
          valid_reg <= 1'b0;
`ifdef ALU_ENTRY_ACCUMULATE_EN
          a_reg     <= y_reg;
          state_reg <= S_B;
`else
          state_reg <= S_A;
`endif
        end
        default: state_reg <= S_A;
      endcase
    end
  end

  always_comb begin
    disp = y_reg;
    case (state_reg)
      S_A, S_B: disp = operand;
      S_OP:     disp = {13'b0, SW[9:7]};
      default:  disp = y_reg;
    endcase
  end

  assign a            = a_reg;
  assign b            = b_reg;
  assign alu_op       = op_reg;
  assign flags_led    = flags_reg;
  assign state_o      = state_reg;
  assign result_valid = valid_reg;

endmodule

// File: tb/tb_alu_operand_entry.sv
// Directed self-checking bench for alu_operand_entry with a behavioural ALU
// model; DEBOUNCE_CYCLES is shortened to 4.
module tb_alu_operand_entry;

  logic        clk;
  logic        reset;
  logic [1:0]  key;
  logic [9:0]  sw;
  logic [15:0] alu_y;
  logic [4:0]  alu_flags;
  logic [15:0] a;
  logic [15:0] b;
  logic [4:0]  alu_op;
  logic [15:0] disp;
  logic [4:0]  flags_led;
  logic [2:0]  state_o;
  logic        result_valid;

  int tests;
  int fails;

  alu_operand_entry #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (3)
  ) dut (
    .CLOCK_50    (clk),
    .reset       (reset),
    .KEY         (key),
    .SW          (sw),
    .alu_y       (alu_y),
    .alu_flags   (alu_flags),
    .a           (a),
    .b           (b),
    .alu_op      (alu_op),
    .disp        (disp),
    .flags_led   (flags_led),
    .state_o     (state_o),
    .result_valid(result_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural ALU: flags are {C, F, Z, L, N}.
  logic [16:0] wide;
  always_comb begin
    wide = 17'd0;
    case (alu_op)
      5'd0:  wide = {1'b0, a} + {1'b0, b};
      5'd8:  wide = {1'b0, a} - {1'b0, b};
      5'd10: wide = {1'b0, a} - {1'b0, b};
      5'd14: wide = {1'b0, a & b};
      5'd16: wide = {1'b0, a | b};
      5'd18: wide = {1'b0, a ^ b};
      5'd20: wide = {1'b0, ~a};
      5'd21: wide = {a, 1'b0};
      default: wide = 17'd0;
    endcase
    alu_y     = wide[15:0];
    alu_flags = {wide[16], 1'b0, (wide[15:0] == 16'd0), ($signed(a) < $signed(b)), wide[15]};
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic press_adv();
    key[0] = 1'b0;
    repeat (10) @(negedge clk);
    key[0] = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic press_clr();
    key[1] = 1'b0;
    repeat (10) @(negedge clk);
    key[1] = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  // Advance out of S_OP, then check the one-cycle S_EXEC and result_valid timing.
  task automatic run_op(input string tag);
    key[0] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (state_o == 3'd3) break;
    end
    check({tag, "_exec_state"}, {13'b0, state_o}, 16'd3);
    check({tag, "_exec_valid"}, {15'b0, result_valid}, 16'd0);
    @(negedge clk);
    check({tag, "_show_state"}, {13'b0, state_o}, 16'd4);
    check({tag, "_show_valid"}, {15'b0, result_valid}, 16'd1);
    repeat (8) @(negedge clk);
    key[0] = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    key   = 2'b11;
    sw    = 10'h000;
    repeat (3) @(negedge clk);
    check("rst_state", {13'b0, state_o}, 16'd0);
    check("rst_a", a, 16'd0);
    check("rst_b", b, 16'd0);
    check("rst_op", {11'b0, alu_op}, 16'd0);
    check("rst_flags", {11'b0, flags_led}, 16'd0);
    check("rst_valid", {15'b0, result_valid}, 16'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Full entry 5 + 16.
    sw = 10'h005;
    @(negedge clk);
    check("a_live_disp", disp, 16'h0005);
    press_adv();
    check("a_latch_state", {13'b0, state_o}, 16'd1);
    check("a_latch", a, 16'h0005);
    sw = 10'h010;
    press_adv();
    check("b_latch_state", {13'b0, state_o}, 16'd2);
    check("b_latch", b, 16'h0010);
    sw = 10'h000;
    @(negedge clk);
    check("op_disp_add", disp, 16'h0000);
    run_op("add");
    check("add_op", {11'b0, alu_op}, 16'd0);
    check("add_disp", disp, 16'h0015);
    check("add_flag_n", {15'b0, flags_led[0]}, 16'd0);
    check("add_a_stable", a, 16'h0005);

`ifdef ALU_ENTRY_ACCUMULATE_EN
    press_adv();
    check("acc_state", {13'b0, state_o}, 16'd1);
    check("acc_a", a, 16'h0015);
    check("acc_valid", {15'b0, result_valid}, 16'd0);
    sw = 10'h002;
    press_adv();
    check("acc_b", b, 16'h0002);
    sw = 10'h000;
    run_op("acc");
    check("acc_disp", disp, 16'h0017);
    press_clr();
    check("acc_clr_state", {13'b0, state_o}, 16'd0);
`else
    press_adv();
    check("show_adv_state", {13'b0, state_o}, 16'd0);
    check("show_adv_a", a, 16'h0005);
    check("show_adv_valid", {15'b0, result_valid}, 16'd0);
`endif

    // Sign extension and subtraction.
    sw = 10'h040;
    @(negedge clk);
    check("sext_live", disp, 16'hFFC0);
    press_adv();
    check("sext_a", a, 16'hFFC0);
    sw = 10'h010;
    press_adv();
    sw = 10'h080;
    @(negedge clk);
    check("op_disp_sub", disp, 16'h0001);
    run_op("sub");
    check("sub_op", {11'b0, alu_op}, 16'd8);
    check("sub_disp", disp, 16'hFFB0);
    check("sub_flag_n", {15'b0, flags_led[0]}, 16'd1);

    // Clear and advance together in S_SHOW: clear wins.
    key = 2'b00;
    repeat (10) @(negedge clk);
    key = 2'b11;
    repeat (10) @(negedge clk);
    check("clr_state", {13'b0, state_o}, 16'd0);
    check("clr_a", a, 16'd0);
    check("clr_b", b, 16'd0);
    check("clr_op", {11'b0, alu_op}, 16'd0);
    check("clr_valid", {15'b0, result_valid}, 16'd0);
    check("clr_flags", {11'b0, flags_led}, 16'd0);

    // Bounce shorter than the debounce window must not advance.
    sw = 10'h003;
    for (int i = 0; i < 4; i++) begin
      key[0] = 1'b0;
      repeat (3) @(negedge clk);
      key[0] = 1'b1;
      repeat (3) @(negedge clk);
    end
    repeat (10) @(negedge clk);
    check("bounce_state", {13'b0, state_o}, 16'd0);
    key[0] = 1'b0;
    repeat (8) @(negedge clk);
    key[0] = 1'b1;
    repeat (12) @(negedge clk);
    check("hold8_state", {13'b0, state_o}, 16'd1);
    check("hold8_a", a, 16'h0003);

    // Asynchronous reset between clock edges while in S_OP.
    press_adv();
    check("pre_rst_state", {13'b0, state_o}, 16'd2);
    #2 reset = 1'b1;
    #1;
    check("arst_state", {13'b0, state_o}, 16'd0);
    check("arst_a", a, 16'd0);
    check("arst_b", b, 16'd0);
    check("arst_disp", disp, 16'h0003);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
